// File: rtl/seq_divider32_pkg.sv
// Shared definitions for the sequential restoring divider: width, FSM encoding,
// the most-negative constant and small arithmetic helpers.
package seq_divider32_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (a & ci) | (b & ci);
    endfunction

    // Two's complement negate when en is set, pass-through otherwise.
    function automatic logic [DIV_WIDTH-1:0] neg_if(input logic [DIV_WIDTH-1:0] v, input logic en);
        return en ? (~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/seq_divider32_div_step.sv
// One combinational restoring step: shift a dividend bit into the partial
// remainder and trial-subtract the divisor through a full-adder ripple.
module div_step
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_no_borrow;

    assign w_shift = {i_rem, i_bit};

    // Ripple subtract: shifted + ~divisor + 1. The divisor is zero-extended to
    // WIDTH+1 bits, so the top stage's inverted operand is 1 and its carry is a|c.
    always_comb begin
        logic v_c;
        v_c         = 1'b1;
        w_diff      = {WIDTH{1'b0}};
        w_no_borrow = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_diff[i] = fa_sum(w_shift[i], ~i_dvs[i], v_c);
            v_c       = fa_carry(w_shift[i], ~i_dvs[i], v_c);
        end
        w_no_borrow = w_shift[WIDTH] | v_c;
    end

    assign o_qbit = w_no_borrow;
    assign o_rem  = w_no_borrow ? w_diff : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider32.sv
// Multi-cycle signed/unsigned divider: one restoring step per clock, sign
// fix-up in a final cycle, registered results with a one-cycle done pulse.
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ctl0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             DivZero,
    output logic             Overflow
);

    localparam int L_CNT_W = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [L_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dz;
    logic               r_ov;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_zero;
    logic               r_overflow;

    logic               w_b_zero;
    logic               w_ovf;
    logic               w_special;
    logic               w_last;
    logic [WIDTH-1:0]   w_step_rem;
    logic               w_qbit;

    assign w_b_zero  = (B == {WIDTH{1'b0}});
    assign w_ovf     = ctl0 & (A == MOST_NEG) & (B == {WIDTH{1'b1}});
    assign w_special = w_b_zero | w_ovf;
    assign w_last    = (r_count == {{(L_CNT_W-1){1'b0}}, 1'b1});

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    // Next-state logic; exceptional operands bypass the iteration loop.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = w_special ? FIX : RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = FIX;
                end else begin
                    w_next_state = RUN;
                end
            end
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register and busy flag derived from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != IDLE);
        end
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= {L_CNT_W{1'b0}};
            r_rem       <= {WIDTH{1'b0}};
            r_dvd       <= {WIDTH{1'b0}};
            r_dvs       <= {WIDTH{1'b0}};
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= {WIDTH{1'b0}};
            r_remainder <= {WIDTH{1'b0}};
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Divide-by-zero must report the raw dividend, so skip abs there.
                        r_dvd   <= w_special ? A : neg_if(A, ctl0 & A[WIDTH-1]);
                        r_dvs   <= neg_if(B, ctl0 & B[WIDTH-1]);
                        r_rem   <= {WIDTH{1'b0}};
                        r_count <= L_CNT_W'(WIDTH);
                        r_neg_q <= ctl0 & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r <= ctl0 & A[WIDTH-1];
                        r_dz    <= w_b_zero;
                        r_ov    <= w_ovf;
                    end else begin
                        r_count <= r_count;
                    end
                end
                RUN: begin
                    r_rem   <= w_step_rem;
                    r_dvd   <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_count <= r_count - {{(L_CNT_W-1){1'b0}}, 1'b1};
                end
                FIX: begin
                    r_done     <= 1'b1;
                    r_div_zero <= r_dz;
                    r_overflow <= r_ov;
                    if (r_dz) begin
                        r_quotient  <= {WIDTH{1'b1}};
                        r_remainder <= r_dvd;
                    end else if (r_ov) begin
                        r_quotient  <= MOST_NEG;
                        r_remainder <= {WIDTH{1'b0}};
                    end else begin
                        r_quotient  <= neg_if(r_dvd, r_neg_q);
                        r_remainder <= neg_if(r_rem, r_neg_r);
                    end
                end
                default: begin
                    r_count <= {L_CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign DivZero   = r_div_zero;
    assign Overflow  = r_overflow;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: arithmetic reference model with a
// schedule of expected done edges, per-cycle compare, directed and random ops.
module tb_seq_divider32;

    typedef struct packed {
        logic        dz;
        logic        ov;
        logic [31:0] q;
        logic [31:0] r;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        ctl0 = 1'b0;
    logic        busy, done, DivZero, Overflow;
    logic [31:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    // Model state
    int   edge_n = 0;
    int   done_edge = -1;
    int   n_done = 0;
    res_t pend = '0;
    res_t held = '0;
    logic m_done = 1'b0;
    logic m_busy = 1'b0;

    logic [69:0] cmp_act, cmp_exp;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .ctl0      (ctl0),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .DivZero   (DivZero),
        .Overflow  (Overflow)
    );

    always #5 clk = ~clk;

    function automatic res_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        res_t   res;
        longint x, y, q, r;
        res = '0;
        if (b == 32'd0) begin
            res.dz = 1'b1;
            res.q  = 32'hFFFF_FFFF;
            res.r  = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.ov = 1'b1;
            res.q  = 32'h8000_0000;
            res.r  = 32'd0;
        end else begin
            if (s) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'd0, a});
                y = longint'({32'd0, b});
            end
            q = x / y;
            r = x % y;
            res.q = q[31:0];
            res.r = r[31:0];
        end
        return res;
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Reference model: decides acceptance of start and when each result appears.
    always @(posedge clk) begin
        int   n;
        res_t p;
        n = edge_n + 1;
        edge_n <= n;
        if (reset) begin
            done_edge <= -1;
            held      <= '0;
            m_done    <= 1'b0;
            m_busy    <= 1'b0;
        end else begin
            m_done <= (n == done_edge);
            if (n == done_edge) begin
                held   <= pend;
                n_done <= n_done + 1;
            end
            if (start && n > done_edge) begin
                p = ref_div(A, B, ctl0);
                pend      <= p;
                done_edge <= n + ((p.dz || p.ov) ? 1 : 33);
                m_busy    <= 1'b1;
            end else begin
                m_busy <= (n < done_edge);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        cmp_act = {busy, done, DivZero, Overflow, quotient, remainder};
        cmp_exp = reset ? 70'd0 : {m_busy, m_done, held.dz, held.ov, held.q, held.r};
        checks++;
        if (cmp_act !== cmp_exp) begin
            errors++;
            $display("FAIL cycle t=%0t got %h want %h", $time, cmp_act, cmp_exp);
        end
    end

    task automatic wait_done(input int pulse_at, output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #2;
            if (pulse_at != 0) start = (k == pulse_at);
            if (done) begin
                lat = k;
                break;
            end
        end
        chk("done_seen", 66'(lat != 0), 66'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input res_t e, input int elat, input int pulse_at);
        int lat;
        A = a; B = b; ctl0 = s; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        A = $urandom; B = $urandom; ctl0 = 1'($urandom);
        wait_done(pulse_at, lat);
        chk("latency", 66'(lat), 66'(elat));
        chk("result", {DivZero, Overflow, quotient, remainder}, e);
        chk("busy_in_done", 66'(busy), 66'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom % 8)
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = $urandom % 16;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int lat;
        int sd;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // Pin the model to hand-computed values.
        chk("ref_100_7",    ref_div(32'd100, 32'd7, 1'b0),                    {2'b00, 32'd14, 32'd2});
        chk("ref_m7_2",     ref_div(32'hFFFF_FFF9, 32'd2, 1'b1),              {2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        chk("ref_7_m2",     ref_div(32'd7, 32'hFFFF_FFFE, 1'b1),              {2'b00, 32'hFFFF_FFFD, 32'd1});
        chk("ref_div0",     ref_div(32'd5, 32'd0, 1'b0),                      {2'b10, 32'hFFFF_FFFF, 32'd5});
        chk("ref_ovf",      ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),      {2'b01, 32'h8000_0000, 32'd0});
        chk("ref_ovf_uns",  ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0),      {2'b00, 32'd0, 32'h8000_0000});

        do_op(32'd100, 32'd7, 1'b0, {2'b00, 32'd14, 32'd2}, 33, 0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, {2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFF}, 33, 0);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, {2'b00, 32'hFFFF_FFFD, 32'd1}, 33, 0);
        do_op(32'd5, 32'd0, 1'b0, {2'b10, 32'hFFFF_FFFF, 32'd5}, 1, 0);
        do_op(32'd6, 32'd3, 1'b0, {2'b00, 32'd2, 32'd0}, 33, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {2'b01, 32'h8000_0000, 32'd0}, 1, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {2'b00, 32'd0, 32'h8000_0000}, 33, 0);
        do_op(32'd1000, 32'd3, 1'b0, {2'b00, 32'd333, 32'd1}, 33, 10);

        // Reset in the middle of a run.
        A = 32'd50; B = 32'd5; ctl0 = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        sd = 0;
        repeat (6) begin
            @(posedge clk);
            #2;
            sd += int'(done);
        end
        chk("no_done_pre_reset", 66'(sd), 66'd0);
        reset = 1'b1;
        #1;
        chk("reset_clears", {busy, done, DivZero, Overflow, quotient, remainder}, 66'd0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        sd = 0;
        repeat (40) begin
            @(posedge clk);
            #2;
            sd += int'(done) + int'(busy);
        end
        chk("no_done_after_reset", 66'(sd), 66'd0);

        // Back-to-back: start held high through the done cycle.
        A = 32'hFFFF_FFFF; B = 32'd1; ctl0 = 1'b0; start = 1'b1;
        @(posedge clk);
        #2;
        A = 32'd20; B = 32'd6;
        wait_done(0, lat);
        chk("b2b_first_lat", 66'(lat), 66'd33);
        chk("b2b_first", {DivZero, Overflow, quotient, remainder}, {2'b00, 32'hFFFF_FFFF, 32'd0});
        wait_done(-1, lat);
        chk("b2b_second_lat", 66'(lat), 66'd34);
        chk("b2b_second", {DivZero, Overflow, quotient, remainder}, {2'b00, 32'd3, 32'd2});

        // Random traffic, including start pulses while busy.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            start = (($urandom % 5) == 0);
            A     = pick();
            B     = pick();
            ctl0  = 1'($urandom);
        end
        start = 1'b0;
        repeat (50) @(posedge clk);
        #2;
        chk("random_ops_done", 66'(n_done > 40), 66'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
